// File: rtl/inst_byte_loader.sv
// inst_byte_loader: byte-serial to little-endian 16-bit word assembler feeding a FWFT FIFO
module inst_byte_loader #(
  parameter int DEPTH = 4,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic          flush,
  output logic [15:0]   inst_out,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [LW-1:0] level,
  output logic          half,
  output logic [7:0]    issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {LOW, HIGH} state_t;
  state_t state_q, state_d;
  logic [7:0] low_q, low_d, cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0] mem [DEPTH];
  logic acc, push, pop;
  assign byte_ready = !flush && (state_q == LOW || level_q != LW'(DEPTH));
  assign inst_valid = level_q != '0 && !flush;
  assign acc = byte_valid && byte_ready;
  assign push = acc && state_q == HIGH;
  assign pop = inst_valid && inst_ready;
  assign inst_out = level_q != '0 ? mem[rd_q] : 16'h0000;
  assign level = level_q;
  assign half = state_q == HIGH;
  assign issued_cnt = cnt_q;
  always_comb begin
    state_d = flush ? LOW : acc ? (state_q == LOW ? HIGH : LOW) : state_q;
    low_d = flush ? 8'h00 : (acc && state_q == LOW) ? byte_in : low_q;
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    cnt_d = cnt_q + 8'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOW;
      low_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      low_q <= low_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {byte_in, low_q};
  end
endmodule

// File: tb/tb_inst_byte_loader.sv
// tb_inst_byte_loader: table vectors, directed corner sequences and random run against a queue model
module tb_inst_byte_loader;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, byte_valid = 0, flush = 0, inst_ready = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, inst_valid, half;
  logic [15:0] inst_out;
  logic [2:0] level;
  logic [7:0] issued_cnt;
  int n_chk = 0, n_fail = 0;
  logic [15:0] q[$];
  bit m_half;
  logic [7:0] m_low;
  int m_cnt, m_pops;
  typedef struct {
    logic f, bv;
    logic [7:0] b;
    logic ir, rdy, vld;
    logic [15:0] out;
    logic [2:0] lvl;
    logic hf;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[9];
  inst_byte_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .flush(flush), .inst_out(inst_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .level(level), .half(half), .issued_cnt(issued_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    q.delete();
    m_half = 0;
    m_low = 0;
    m_cnt = 0;
    m_pops = 0;
  endfunction
  function automatic bit m_rdy();
    return !flush && (!m_half || q.size() != DEPTH);
  endfunction
  function automatic bit m_vld();
    return q.size() != 0 && !flush;
  endfunction
  function automatic void model_update();
    bit rdy = m_rdy(), vld = m_vld();
    if (flush) begin
      q.delete();
      m_half = 0;
      m_low = 0;
    end else begin
      if (vld && inst_ready) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % 256;
        m_pops++;
      end
      if (byte_valid && rdy) begin
        if (!m_half) m_low = byte_in;
        else q.push_back({byte_in, m_low});
        m_half = !m_half;
      end
    end
  endfunction
  task automatic check_model();
    chk("byte_ready", byte_ready, m_rdy());
    chk("inst_valid", inst_valid, m_vld());
    chk("inst_out", inst_out, q.size() != 0 ? q[0] : 16'h0);
    chk("level", level, q.size());
    chk("half", half, m_half);
    chk("issued_cnt", issued_cnt, m_cnt);
  endtask
  task automatic drive(input logic f, input logic bv, input logic [7:0] b, input logic ir);
    flush = f;
    byte_valid = bv;
    byte_in = b;
    inst_ready = ir;
    #1;
  endtask
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    logic [7:0] b, seq[9];
    logic [7:0] saved;
    tbl[0] = '{1'b0, 1'b1, 8'h63, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 1'b1, 8'h2A, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 8'd0};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h2A63, 3'd1, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 16'h2A63, 3'd1, 1'b0, 8'd0};
    tbl[4] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 16'h2A63, 3'd1, 1'b1, 8'd0};
    tbl[5] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[6] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 8'd0};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h4433, 3'd1, 1'b0, 8'd0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd1};
    model_reset();
    #2;
    chk("rst_ready", byte_ready, 1);
    chk("rst_valid", inst_valid, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_level", level, 0);
    chk("rst_half", half, 0);
    chk("rst_cnt", issued_cnt, 0);
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].f, tbl[i].bv, tbl[i].b, tbl[i].ir);
      chk($sformatf("t%0d_ready", i), byte_ready, tbl[i].rdy);
      chk($sformatf("t%0d_valid", i), inst_valid, tbl[i].vld);
      chk($sformatf("t%0d_out", i), inst_out, tbl[i].out);
      chk($sformatf("t%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("t%0d_half", i), half, tbl[i].hf);
      chk($sformatf("t%0d_cnt", i), issued_cnt, tbl[i].cnt);
      step();
    end
    do_reset();
    seq = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05};
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, seq[i], 0);
      check_model();
      step();
    end
    drive(0, 1, 8'h05, 0);
    chk("full_ready", byte_ready, 0);
    chk("full_level", level, 4);
    chk("full_half", half, 1);
    step();
    drive(0, 1, 8'h05, 1);
    chk("full_pop_ready", byte_ready, 0);
    chk("full_head", inst_out, 16'h0101);
    step();
    drive(0, 1, 8'h05, 0);
    chk("freed_ready", byte_ready, 1);
    chk("freed_level", level, 3);
    step();
    chk("refill_level", level, 4);
    for (int i = 2; i <= 5; i++) begin
      drive(0, 0, 0, 1);
      chk($sformatf("drain_%0d", i), inst_out, {2{8'(i)}});
      check_model();
      step();
    end
    chk("drained_level", level, 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'(8'h10 + i), 0);
      check_model();
      step();
    end
    drive(0, 1, 8'h99, 1);
    chk("pp_level_before", level, 2);
    step();
    drive(0, 0, 0, 0);
    chk("pp_level", level, 2);
    chk("pp_cnt", issued_cnt, 1);
    chk("pp_head", inst_out, 16'h1312);
    check_model();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'(i + 1), 0);
      step();
    end
    drive(0, 1, 8'hAA, 1);
    check_model();
    step();
    drive(0, 0, 0, 0);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_half", half, 1);
    chk("pre_rst_cnt", issued_cnt, 1);
    rst = 1;
    #1;
    chk("arst_valid", inst_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_half", half, 0);
    chk("arst_cnt", issued_cnt, 0);
    chk("arst_out", inst_out, 0);
    chk("arst_ready", byte_ready, 1);
    do_reset();
    saved = 0;
    for (int c = 0; c < 3000 && m_pops < 257; c++) begin
      b = 8'($urandom);
      drive(c == 300, 1, b, 1);
      check_model();
      if (c == 300) saved = issued_cnt;
      step();
      if (c == 300) chk("flush_cnt", issued_cnt, m_cnt);
      if (c == 300) chk("flush_cnt_same", m_cnt, saved);
      if (m_pops == 256 && flush == 0 && inst_valid == 0) chk("wrap_empty", issued_cnt, 0);
    end
    chk("pops_reached", m_pops, 257);
    chk("cnt_after_257", issued_cnt, 1);
    do_reset();
    b = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 16) == 0, $urandom % 4 != 0, b, $urandom % 3 == 0);
      check_model();
      if (byte_valid && m_rdy()) b = 8'($urandom);
      step();
      byte_in = b;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
